// File: rtl/mux_pkg.sv
// Shared datapath constants for the registered word selectors.
package mux_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic SEL_A0 = 1'b0;
  localparam logic SEL_A1 = 1'b1;

endpackage

// File: rtl/mux2_comb.sv
// Combinational WIDTH-wide 2:1 selector with zero detect.
// Parity output present only when MUX32_PARITY_EN is defined.
module mux2_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic             zero
`ifdef MUX32_PARITY_EN
  ,
  output logic             par
`endif
);

  // Plain ternary so an unknown select merges a0/a1 bitwise.
  assign y    = (s == SEL_A1) ? a1 : a0;
  assign zero = (y == '0);

`ifdef MUX32_PARITY_EN
  assign par = ^y;
`endif

endmodule

// File: rtl/mux32.sv
// Registered 2:1 word selector with registered zero flag and select echo.
// Optional even-parity output out_par when MUX32_PARITY_EN is defined.
module mux32
  import mux_pkg::*;
#(
  parameter int               WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  output logic             out_zero,
  output logic             s_q
`ifdef MUX32_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_zero;
`ifdef MUX32_PARITY_EN
  logic             sel_par;
`endif

  mux2_comb #(
    .WIDTH (WIDTH)
  ) u_sel (
    .a0   (a0),
    .a1   (a1),
    .s    (s),
    .y    (sel_word),
    .zero (sel_zero)
`ifdef MUX32_PARITY_EN
    ,
    .par  (sel_par)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= RST_VAL;
      out_zero <= (RST_VAL == '0);
      s_q      <= SEL_A0;
    end else begin
      out      <= sel_word;
      out_zero <= sel_zero;
      s_q      <= s;
    end
  end

`ifdef MUX32_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_par <= ^RST_VAL;
    else     out_par <= sel_par;
  end
`endif

endmodule

// File: tb/tb_mux32.sv
// Bench for mux32: directed vector table, hand-written reset sequences,
// and randomized traffic against a reference model.
module tb_mux32;
  import mux_pkg::*;

  localparam int W = DATA_W;

  typedef struct {
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic         s;
    logic [W-1:0] exp_out;
    logic         exp_zero;
    logic         exp_sq;
  } vec_t;

  logic         clk;
  logic         rst;
  word_t        a0;
  word_t        a1;
  logic         s;
  word_t        out;
  logic         out_zero;
  logic         s_q;
`ifdef MUX32_PARITY_EN
  logic         out_par;
`endif

  int n_checks;
  int n_pass;

  logic [W+1:0] exp_q[$];

  mux32 dut (
    .a0       (a0),
    .a1       (a1),
    .s        (s),
    .out      (out),
    .clk      (clk),
    .rst      (rst),
    .out_zero (out_zero),
    .s_q      (s_q)
`ifdef MUX32_PARITY_EN
    ,
    .out_par  (out_par)
`endif
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [W-1:0] v0, input logic [W-1:0] v1, input logic sv);
    a0 = v0;
    a1 = v1;
    s  = sv;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pick the candidate indexed by the select value.
  function automatic logic [W+1:0] model(input logic [W-1:0] v0, input logic [W-1:0] v1,
                                          input logic sv);
    logic [W-1:0] cand [2];
    logic [W-1:0] w;
    cand[0] = v0;
    cand[1] = v1;
    w = cand[int'(sv)];
    return {sv, (w == 0), w};
  endfunction

  function automatic logic parity_of(input logic [W-1:0] w);
    return logic'($countones(w) % 2);
  endfunction

  vec_t vecs [6];

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] prev;
    logic [W-1:0] r0, r1;
    logic         rs;

    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{a0: 32'd11,         a1: 32'd0,   s: 1'b0, exp_out: 32'd11,  exp_zero: 1'b0, exp_sq: 1'b0};
    vecs[1] = '{a0: 32'd1,          a1: 32'd110, s: 1'b1, exp_out: 32'd110, exp_zero: 1'b0, exp_sq: 1'b1};
    vecs[2] = '{a0: 32'd12,         a1: 32'd40,  s: 1'b0, exp_out: 32'd12,  exp_zero: 1'b0, exp_sq: 1'b0};
    vecs[3] = '{a0: 32'hFFFFFFFF,   a1: 32'd0,   s: 1'b1, exp_out: 32'd0,   exp_zero: 1'b1, exp_sq: 1'b1};
    vecs[4] = '{a0: 32'h0,          a1: 32'h5,   s: 1'b0, exp_out: 32'd0,   exp_zero: 1'b1, exp_sq: 1'b0};
    vecs[5] = '{a0: 32'h8000_0000,  a1: 32'h1,   s: 1'b1, exp_out: 32'h1,   exp_zero: 1'b0, exp_sq: 1'b1};

    // Reset asserted with the clock running
    rst = 1'b1;
    drive(32'd11, 32'd0, 1'b0);
    #1;
    check("reset_out", 64'(out), 64'd0);
    check("reset_zero", 64'(out_zero), 64'd1);
    check("reset_sq", 64'(s_q), 64'd0);
    after_edge();
    drive(32'd11, 32'd0, 1'b1);
    after_edge();
    check("reset_hold_out", 64'(out), 64'd0);
    check("reset_hold_sq", 64'(s_q), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, consecutive edges with no bubble
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a0, vecs[i].a1, vecs[i].s);
      #2;
      check($sformatf("vec%0d_pre_edge_out", i), 64'(out), 64'(prev));
      after_edge();
      check($sformatf("vec%0d_out", i), 64'(out), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d_zero", i), 64'(out_zero), 64'(vecs[i].exp_zero));
      check($sformatf("vec%0d_sq", i), 64'(s_q), 64'(vecs[i].exp_sq));
      prev = vecs[i].exp_out;
      @(negedge clk);
    end

    // Asynchronous reset pulse between edges while out=12
    drive(32'd12, 32'd40, 1'b0);
    after_edge();
    check("pre_pulse_out", 64'(out), 64'd12);
    @(negedge clk);
    drive(32'h7, 32'h0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("pulse_out", 64'(out), 64'd0);
    check("pulse_zero", 64'(out_zero), 64'd1);
    #1 rst = 1'b0;
    after_edge();
    check("resume_out", 64'(out), 64'h7);
    check("resume_zero", 64'(out_zero), 64'd0);
`ifdef MUX32_PARITY_EN
    check("resume_par", 64'(out_par), 64'd1);
`endif

    // Edge coincident with reset is ignored; next edge captures
    @(negedge clk);
    rst = 1'b1;
    drive(32'd9, 32'd3, 1'b1);
    after_edge();
    check("rst_edge_out", 64'(out), 64'd0);
    check("rst_edge_sq", 64'(s_q), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    after_edge();
    check("post_rst_out", 64'(out), 64'd3);
    check("post_rst_sq", 64'(s_q), 64'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r0 = $urandom;
      r1 = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: r0 = '0;
        1: r1 = '0;
        2: r1 = r0;
        default: ;
      endcase
      drive(r0, r1, rs);
      exp_q.push_back(model(r0, r1, rs));
      after_edge();
      e = exp_q.pop_front();
      check("rand_out", 64'(out), 64'(e[W-1:0]));
      check("rand_zero", 64'(out_zero), 64'(e[W]));
      check("rand_sq", 64'(s_q), 64'(e[W+1]));
`ifdef MUX32_PARITY_EN
      check("rand_par", 64'(out_par), 64'(parity_of(e[W-1:0])));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux32.md
Name: mux32

Overview:
- Registered 2:1 word selector used on the 32-bit pipelined datapath wherever a stage picks between two candidate operands or results.
- Select and data are sampled on the rising clock edge, and the chosen word is held in a pipeline register.
- Consumers see the result one cycle after the inputs are presented.
- Adds a registered zero flag and a registered select echo, which feed downstream forwarding and branch logic.

Parameters:
- WIDTH, 32, data width of a0, a1 and out; legal range 1..64.
- RST_VAL, {WIDTH{1'b0}}, value loaded into out on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- a0  input  WIDTH  candidate word selected when s=0.
- a1  input  WIDTH  candidate word selected when s=1.
- s  input  1  select.
- out  output  WIDTH  registered selected word.
- out_zero  output  1  registered flag, 1 when the selected word is all zeros.
- s_q  output  1  registered copy of s, aligned with out.
- Declaration order is a0, a1, s, out, clk, rst, out_zero, s_q. Existing positional instantiations (a0, a1, s, out, clk) stay valid. New instances connect rst by name.

Behaviour:
- Reset: rst=1 asynchronously forces out=RST_VAL, out_zero=(RST_VAL==0), s_q=0. The reset acts immediately, without waiting for a clock edge, and holds for as long as rst is high.
- Reset deassertion: the first capture happens at the first rising clk edge with rst=0.
- Normal operation, at each posedge clk with rst=0:
  - out <= s ? a1 : a0.
  - out_zero <= ((s ? a1 : a0) == 0).
  - s_q <= s.
- Latency: exactly one clock edge. Inputs that change between edges have no effect until the next posedge.
- Outputs hold their value between edges, and there is no enable.
- Unknown select: if s is X or Z at an edge, out captures the bitwise merge. Bits where a0 and a1 agree take that value; bits where they differ become X. This is ordinary ternary semantics, and s_q captures X.
- Reset during operation: an edge coincident with rst=1 is ignored. The capture on the next edge after deassertion uses the inputs present at that edge.
- The block has no combinational path from any input to any output.

Optional Feature:
- Macro MUX32_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit, declared after s_q), registered in step with out.
  - out_par equals the XOR-reduction (even-parity bit) of the selected word.
  - out_par resets to the parity of RST_VAL.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package mux_pkg holds:
  - the constant DATA_W=32, used as the default for WIDTH;
  - the typedef word_t (logic [DATA_W-1:0]);
  - the constants SEL_A0=1'b0 and SEL_A1=1'b1.
- One natural sub-module, mux2_comb: a purely combinational WIDTH-wide 2:1 selector, plus a zero-detect output and, when the macro is defined, a parity output.
- mux32 instantiates mux2_comb and the output register bank.

Test Plan:
- Reset: assert rst with clk running, a0=11, a1=0, s=0 -> out=0, out_zero=1, s_q=0 immediately and throughout the assertion.
- Select a0: after reset release, s=0, a0=11, a1=0 presented between edges -> at the next posedge out=11, out_zero=0, s_q=0. Before that edge, out keeps its prior value.
- Select a1: s=1, a0=1, a1=110 -> after one posedge out=110, s_q=1.
- Back-to-back switching: s=0, a0=12, a1=40 on the cycle following s=1, a0=1, a1=110 -> out=110, then 12 on consecutive edges, with no bubble.
- Zero flag: s=1, a0=32'hFFFFFFFF, a1=0 -> out=0, out_zero=1.
- Asynchronous reset mid-stream: rst pulsed between edges while out=12 -> out=0 before the next edge. Captures resume on the first edge after deassertion. With MUX32_PARITY_EN defined and a0=32'h7 selected, out_par=1.
